// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer and its command FIFO.
`default_nettype none

package alu_pkg;
   localparam int ALU_W  = 8;
   localparam int OPC_W  = 4;
   localparam int CMD_W  = 2 * ALU_W + OPC_W;

   // Bit positions inside the 4-bit {Z,N,C,V} flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RSP   = 2'd3
   } issuer_state_t;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [OPC_W-1:0] opcode;
   } alu_cmd_t;
endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO (operands + opcode); extra pointer bit separates full from empty.
`default_nettype none

module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives the start/busy/done handshake with a watchdog,
// and returns tagged results on a valid/ready response stream.
`default_nettype none

module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ALU_W-1:0] cmd_a,
   input  logic [ALU_W-1:0] cmd_b,
   input  logic [OPC_W-1:0] cmd_opcode,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ALU_W-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_timeout,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             alu_start,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   output logic [OPC_W-1:0] alu_opcode,
   input  logic             alu_busy,
   input  logic             alu_done,
   input  logic [ALU_W-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_c,
   input  logic             alu_v
);
   localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   issuer_state_t    state;
   alu_cmd_t         head;
   logic             full;
   logic             empty;
   logic             pop;
   logic [WD_W-1:0]  watchdog;
   logic [TAG_W-1:0] tag_cnt;

   assign cmd_ready = !full;
   // Never start while a previous (possibly abandoned) ALU operation is still active
   assign pop = (state == IDLE) && !empty && !alu_busy && !alu_done;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata ({cmd_a, cmd_b, cmd_opcode}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         watchdog    <= '0;
         tag_cnt     <= '0;
         alu_start   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_opcode  <= '0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_timeout <= 1'b0;
         rsp_tag     <= '0;
      end else begin
         alu_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  alu_a      <= head.a;
                  alu_b      <= head.b;
                  alu_opcode <= head.opcode;
                  rsp_tag    <= tag_cnt;
                  alu_start  <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               watchdog <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (alu_done) begin
                  rsp_result        <= alu_result;
                  rsp_flags[FLAG_Z] <= alu_z;
                  rsp_flags[FLAG_N] <= alu_n;
                  rsp_flags[FLAG_C] <= alu_c;
                  rsp_flags[FLAG_V] <= alu_v;
                  rsp_timeout       <= 1'b0;
                  rsp_valid         <= 1'b1;
                  state             <= RSP;
               end else if (watchdog == WD_W'(TIMEOUT)) begin
                  rsp_result  <= '0;
                  rsp_flags   <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= RSP;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  tag_cnt   <= tag_cnt + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench: behavioural ALU responder, queue-based scoreboard, directed and random traffic.
`default_nettype none

module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int DEPTH     = 4;
   localparam int TIMEOUT   = 15;
   localparam int TAG_W     = 4;
   localparam int SIG_START = 0;
   localparam int SIG_RSP   = 1;
   localparam int N_RAND    = 40;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [ALU_W-1:0] cmd_a = '0;
   logic [ALU_W-1:0] cmd_b = '0;
   logic [OPC_W-1:0] cmd_opcode = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [ALU_W-1:0] rsp_result;
   logic [3:0]       rsp_flags;
   logic             rsp_timeout;
   logic [TAG_W-1:0] rsp_tag;
   logic             alu_start;
   logic [ALU_W-1:0] alu_a;
   logic [ALU_W-1:0] alu_b;
   logic [OPC_W-1:0] alu_opcode;
   logic             alu_busy;
   logic             alu_done;
   logic [ALU_W-1:0] alu_result;
   logic             alu_z, alu_n, alu_c, alu_v;

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .TAG_W   (TAG_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_opcode  (cmd_opcode),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .rsp_timeout (rsp_timeout),
      .rsp_tag     (rsp_tag),
      .alu_start   (alu_start),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_busy    (alu_busy),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .alu_c       (alu_c),
      .alu_v       (alu_v)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference ALU: returns {result, Z, N, C, V}; opcode 0 add, 1 sub, 2 and, 3 xor (mod 4)
   function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      int   ua, ub, sa, sb, ru, rs;
      logic [7:0] r;
      logic c, v;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      c = 1'b0; v = 1'b0;
      case (op % 4)
         0: begin ru = ua + ub; rs = sa + sb; r = 8'(ru); c = (ru > 255); v = (rs > 127) || (rs < -128); end
         1: begin ru = ua - ub; rs = sa - sb; r = 8'(ru); c = (ua < ub);  v = (rs > 127) || (rs < -128); end
         2: r = a & b;
         default: r = a ^ b;
      endcase
      return {r, (r == 8'h00), r[7], c, v};
   endfunction

   // Behavioural ALU: busy the cycle after start, done (with result) the cycle after that
   bit         hang = 1'b0;
   bit         force_busy = 1'b0;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic [11:0] m_out = '0;
   logic [7:0] ma = '0, mb = '0;
   logic [3:0] mo = '0;

   always @(posedge clk) begin
      m_done <= 1'b0;
      if (m_busy) begin
         m_busy <= 1'b0;
         if (!hang) begin
            m_done <= 1'b1;
            m_out  <= ref_alu(ma, mb, mo);
         end
      end
      if (alu_start) begin
         m_busy <= 1'b1;
         ma <= alu_a; mb <= alu_b; mo <= alu_opcode;
      end
   end

   assign alu_busy   = m_busy | force_busy;
   assign alu_done   = m_done;
   assign alu_result = m_out[11:4];
   assign alu_z      = m_out[3];
   assign alu_n      = m_out[2];
   assign alu_c      = m_out[1];
   assign alu_v      = m_out[0];

   typedef struct packed { logic [7:0] a; logic [7:0] b; logic [3:0] op; } tb_cmd_t;
   typedef struct packed { logic [7:0] res; logic [3:0] flags; logic to; } tb_exp_t;

   tb_cmd_t          cmd_q[$];
   tb_exp_t          exp_q[$];
   int               n_acc = 0;
   logic [TAG_W-1:0] exp_tag = '0;

   // Scoreboard: samples just after the falling edge, predicting handshakes at the next rising edge
   initial begin
      logic        p_start, p_hold;
      logic [16:0] p_data;
      tb_cmd_t     c;
      tb_exp_t     e;
      logic [11:0] r;
      p_start = 1'b0; p_hold = 1'b0; p_data = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            cmd_q.delete(); exp_q.delete();
            exp_tag = '0; p_start = 1'b0; p_hold = 1'b0;
         end else begin
            if (p_hold) begin
               check("rsp_hold_valid", rsp_valid, 1'b1);
               check("rsp_hold_data", {rsp_result, rsp_flags, rsp_timeout, rsp_tag}, p_data);
            end
            if (alu_start) begin
               check("start_pulse_width", p_start, 1'b0);
               if (cmd_q.size() == 0) begin
                  check("start_without_cmd", 1, 0);
               end else begin
                  c = cmd_q.pop_front();
                  check("alu_operands", {alu_a, alu_b, alu_opcode}, {c.a, c.b, c.op});
                  r = ref_alu(c.a, c.b, c.op);
                  e.to    = hang;
                  e.res   = hang ? 8'h00 : r[11:4];
                  e.flags = hang ? 4'h0  : r[3:0];
                  exp_q.push_back(e);
               end
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_result", rsp_result, e.res);
                  check("rsp_flags", rsp_flags, e.flags);
                  check("rsp_timeout", rsp_timeout, e.to);
                  check("rsp_tag", rsp_tag, exp_tag);
                  exp_tag = exp_tag + 1'b1;
               end
            end
            if (cmd_valid && cmd_ready) begin
               cmd_q.push_back({cmd_a, cmd_b, cmd_opcode});
               n_acc++;
            end
            p_start = alu_start;
            p_hold  = rsp_valid && !rsp_ready;
            p_data  = {rsp_result, rsp_flags, rsp_timeout, rsp_tag};
         end
      end
   end

   // All stimulus tasks are entered and left on a falling edge
   task automatic try_push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                           input int lim, output bit ok);
      int n;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op;
      n = 0;
      while (!cmd_ready && n < lim) begin
         @(negedge clk);
         n++;
      end
      ok = cmd_ready;
      if (ok) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      bit ok;
      try_push(a, b, op, 200, ok);
      check("push_accepted", ok, 1'b1);
      if (!ok) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_for(input int sel, output int n);
      n = 0;
      while (((sel == SIG_START) ? !alu_start : !rsp_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check((sel == SIG_START) ? "wait_start_bound" : "wait_rsp_bound", (n < 100), 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((cmd_q.size() != 0 || exp_q.size() != 0 || rsp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_bound", (n < 500), 1'b1);
   endtask

   initial begin
      int  n1, n2, cnt, acc, base, sent, acc_seen, cyc;
      bit  ok;
      logic [7:0] pa, pb;
      logic [3:0] po;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_alu_start", alu_start, 1'b0);
      check("rst_outputs", {alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, rsp_timeout, rsp_tag}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single add, latency from push
      push(8'h05, 8'h03, 4'h0);
      wait_for(SIG_START, n1);
      check("lat_start", n1, 1);
      wait_for(SIG_RSP, n2);
      check("lat_rsp", n2, 3);
      check("add_result", rsp_result, 8'h08);
      check("add_flags", rsp_flags, 4'b0000);
      check("add_tag", rsp_tag, 0);
      @(negedge clk);

      // Signed overflow
      push(8'h7F, 8'h01, 4'h0);
      wait_for(SIG_RSP, n2);
      check("ovf_result", rsp_result, 8'h80);
      check("ovf_flags", rsp_flags, 4'b0101);
      check("ovf_tag", rsp_tag, 1);
      @(negedge clk);

      // Watchdog timeout, then a normal command
      hang = 1'b1;
      push(8'h11, 8'h22, 4'h0);
      wait_for(SIG_START, n1);
      wait_for(SIG_RSP, n2);
      check("timeout_lat", n2, TIMEOUT + 2);
      check("timeout_flag", rsp_timeout, 1'b1);
      check("timeout_data", {rsp_result, rsp_flags}, 0);
      @(negedge clk);
      hang = 1'b0;
      push(8'h10, 8'h20, 4'h1);
      wait_for(SIG_RSP, n2);
      check("post_timeout_flag", rsp_timeout, 1'b0);
      check("post_timeout_result", {rsp_result, rsp_flags}, {8'hF0, 4'b0110});
      @(negedge clk);

      // Backpressure: one command parks in RSP, DEPTH more fill the FIFO
      rsp_ready = 1'b0;
      acc = 0;
      pa = '0; pb = '0; po = '0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         pa = 8'(i * 17); pb = 8'(i * 3 + 1); po = 4'(i % 4);
         try_push(pa, pb, po, 8, ok);
         if (!ok) break;
         acc++;
      end
      check("bp_accepted", acc, DEPTH + 1);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      rsp_ready = 1'b1;
      push(pa, pb, po);
      drain();

      // Busy guard
      force_busy = 1'b1;
      push(8'h21, 8'h0F, 4'h2);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (alu_start) cnt++;
         @(negedge clk);
      end
      check("busy_no_start", cnt, 0);
      force_busy = 1'b0;
      @(negedge clk);
      check("busy_release_start", alu_start, 1'b1);
      wait_for(SIG_RSP, n2);
      @(negedge clk);

      // Reset in the middle of WAIT
      hang = 1'b1;
      push(8'h01, 8'h02, 4'h3);
      wait_for(SIG_START, n1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_valid_start", {rsp_valid, alu_start}, 0);
      check("midrst_outputs", {alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, rsp_timeout, rsp_tag}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hang  = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_fifo_empty", alu_start, 1'b0);
      push(8'h40, 8'h40, 4'h0);
      wait_for(SIG_RSP, n2);
      check("midrst_tag", rsp_tag, 0);
      check("midrst_result", {rsp_result, rsp_flags}, {8'h80, 4'b0101});
      @(negedge clk);

      // Random traffic with random consumer stalls
      base = n_acc; sent = 0; acc_seen = n_acc; cyc = 0;
      while (cyc < 4000 && !(sent == N_RAND && n_acc - base == N_RAND &&
                             cmd_q.size() == 0 && exp_q.size() == 0 && !rsp_valid)) begin
         if (!cmd_valid || n_acc != acc_seen) begin
            acc_seen = n_acc;
            if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
               cmd_valid  = 1'b1;
               cmd_a      = 8'($urandom);
               cmd_b      = 8'($urandom);
               cmd_opcode = 4'($urandom);
               sent++;
            end else begin
               cmd_valid = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cyc++;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      check("random_drained", (cyc < 4000), 1'b1);
      check("random_count", n_acc - base, N_RAND);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
